pueo_trig_accept: RTL and testbench

//  Downstream of the L2 trigger. Accepts the master trigger pulse and the delay-matched TURFIO metadata.

---
 rtl/pueo_trig_accept.sv | 134 +++++++++++++
 tb/tb_pueo_trig_accept.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pueo_trig_accept.sv
// rtl/pueo_trig_accept.sv - trigger accept, event stamping, event FIFO and L2 holdoff/dead gating
// Optional build macro: PUEO_TRIG_ACCEPT_STATS_EN enables the saturating drop counter.
module pueo_trig_accept #(
    parameter int DEPTH        = 4,
    parameter int MAX_OUTSTAND = 8
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         ce_i,
    input  logic         run_en_i,
    input  logic [15:0]  holdoff_len_i,
    input  logic         trig_i,
    input  logic [63:0]  tio0_meta_i,
    input  logic [63:0]  tio1_meta_i,
    input  logic [63:0]  tio2_meta_i,
    input  logic [63:0]  tio3_meta_i,
    input  logic         event_done_i,
    output logic         ev_valid_o,
    input  logic         ev_ready_i,
    output logic [31:0]  ev_number_o,
    output logic [31:0]  ev_time_o,
    output logic [255:0] ev_meta_o,
    output logic         holdoff_o,
    output logic         dead_o,
    output logic [15:0]  drop_count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [7:0]  MAX_OS   = 8'(MAX_OUTSTAND);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]    state, state_next;
    logic [31:0]   timestamp;
    logic [31:0]   evnum;
    logic [7:0]    outstand, outstand_next;
    logic [15:0]   hold_cnt;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_next;
    logic [319:0]  mem [DEPTH];
    logic          fifo_full, accept, pop, start_run;

    assign fifo_full  = (count == FULL_CNT);
    assign holdoff_o  = (hold_cnt != 16'd0);
    assign ev_valid_o = (count != '0);
    assign pop        = ev_valid_o && ev_ready_i;
    assign start_run  = (state == ST_IDLE) && run_en_i;
    // fifo_full is already reflected in dead_o; kept here so a full FIFO can never be overwritten
    assign accept     = trig_i && (state == ST_RUN) && !holdoff_o && !dead_o && !fifo_full;

    assign {ev_number_o, ev_time_o, ev_meta_o} = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (accept && !pop)
            count_next = count + (AW+1)'(1);
        else if (!accept && pop)
            count_next = count - (AW+1)'(1);

        outstand_next = outstand;
        if (accept && !event_done_i)
            outstand_next = outstand + 8'd1;
        else if (!accept && event_done_i && (outstand != 8'd0))
            outstand_next = outstand - 8'd1;

        state_next = state;
        unique case (state)
            ST_IDLE:  if (run_en_i) state_next = ST_RUN;
            ST_RUN:   if (!run_en_i) state_next = (outstand_next != 8'd0) ? ST_DRAIN : ST_IDLE;
            ST_DRAIN: if (outstand == 8'd0) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= ST_IDLE;
            timestamp <= 32'd0;
            evnum     <= 32'd0;
            outstand  <= 8'd0;
            hold_cnt  <= 16'd0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            dead_o    <= 1'b1;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            state     <= state_next;
            timestamp <= timestamp + 32'd1;
            outstand  <= outstand_next;
            count     <= count_next;
            // registered from next-state so L2 sees the gate one clk after the causing event
            dead_o    <= (state_next != ST_RUN) || (outstand_next == MAX_OS) || (count_next == FULL_CNT);

            if (start_run)
                evnum <= 32'd0;
            else if (accept)
                evnum <= evnum + 32'd1;

            if (accept)
                hold_cnt <= holdoff_len_i;
            else if (ce_i && holdoff_o)
                hold_cnt <= hold_cnt - 16'd1;

            if (accept) begin
                mem[wr_ptr] <= {evnum, timestamp, tio3_meta_i, tio2_meta_i, tio1_meta_i, tio0_meta_i};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
        end
    end

`ifdef PUEO_TRIG_ACCEPT_STATS_EN
    logic [15:0] drop_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            drop_cnt <= 16'd0;
        else if (start_run)
            drop_cnt <= 16'd0;
        else if (trig_i && !accept && (drop_cnt != 16'hFFFF))
            drop_cnt <= drop_cnt + 16'd1;
    end

    assign drop_count_o = drop_cnt;
`else
    assign drop_count_o = 16'd0;
`endif

endmodule

// File: tb/tb_pueo_trig_accept.sv
// tb/tb_pueo_trig_accept.sv - self-checking bench for pueo_trig_accept with a queue-based reference model
module tb_pueo_trig_accept;
    localparam int DEPTH = 4;
    localparam int MAX   = 8;
`ifdef PUEO_TRIG_ACCEPT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         clk_i = 1'b0;
    logic         rst_n_i;
    logic         ce_i;
    logic         run_en_i;
    logic [15:0]  holdoff_len_i;
    logic         trig_i;
    logic [63:0]  tio0_meta_i, tio1_meta_i, tio2_meta_i, tio3_meta_i;
    logic         event_done_i;
    logic         ev_valid_o;
    logic         ev_ready_i;
    logic [31:0]  ev_number_o;
    logic [31:0]  ev_time_o;
    logic [255:0] ev_meta_o;
    logic         holdoff_o;
    logic         dead_o;
    logic [15:0]  drop_count_o;

    pueo_trig_accept #(.DEPTH(DEPTH), .MAX_OUTSTAND(MAX)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .ce_i(ce_i), .run_en_i(run_en_i),
        .holdoff_len_i(holdoff_len_i), .trig_i(trig_i),
        .tio0_meta_i(tio0_meta_i), .tio1_meta_i(tio1_meta_i),
        .tio2_meta_i(tio2_meta_i), .tio3_meta_i(tio3_meta_i),
        .event_done_i(event_done_i), .ev_valid_o(ev_valid_o), .ev_ready_i(ev_ready_i),
        .ev_number_o(ev_number_o), .ev_time_o(ev_time_o), .ev_meta_o(ev_meta_o),
        .holdoff_o(holdoff_o), .dead_o(dead_o), .drop_count_o(drop_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0]  num;
        logic [31:0]  t;
        logic [255:0] meta;
    } rec_t;

    // reference model: mode 0=idle 1=run 2=drain, FIFO as a queue of records
    rec_t        mq[$];
    int          m_mode, m_out, m_hold, m_drops;
    bit          m_dead;
    logic [31:0] m_evnum, m_ts;
    logic [31:0] popped[$];
    int          n_vec, n_err;

    task automatic model_reset();
        mq.delete();
        m_mode = 0; m_out = 0; m_hold = 0; m_drops = 0;
        m_dead = 1'b1; m_evnum = 32'd0; m_ts = 32'd0;
    endtask

    task automatic model_step();
        bit   acc, pop_;
        int   old_out;
        rec_t r;
        acc  = trig_i && (m_mode == 1) && (m_hold == 0) && !m_dead && (mq.size() < DEPTH);
        pop_ = (mq.size() > 0) && ev_ready_i;
        old_out = m_out;
        if (trig_i && !acc && m_drops < 65535) m_drops++;
        if (pop_) mq.delete(0);
        if (acc) begin
            r.num = m_evnum; r.t = m_ts;
            r.meta = {tio3_meta_i, tio2_meta_i, tio1_meta_i, tio0_meta_i};
            mq.push_back(r);
            m_evnum = m_evnum + 32'd1;
        end
        if (acc && !event_done_i) m_out++;
        else if (!acc && event_done_i && m_out > 0) m_out--;
        if (acc) m_hold = int'(holdoff_len_i);
        else if (ce_i && m_hold > 0) m_hold--;
        case (m_mode)
            0: if (run_en_i) begin m_mode = 1; m_evnum = 32'd0; m_drops = 0; end
            1: if (!run_en_i) m_mode = (m_out != 0) ? 2 : 0;
            default: if (old_out == 0) m_mode = 0;
        endcase
        m_dead = (m_mode != 1) || (m_out == MAX) || (mq.size() == DEPTH);
        m_ts = m_ts + 32'd1;
    endtask

    task automatic tick();
        if (ev_valid_o && ev_ready_i) popped.push_back(ev_number_o);
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
        ce_i = ~ce_i;
    endtask

    task automatic rand_meta();
        tio0_meta_i = {$urandom, $urandom}; tio1_meta_i = {$urandom, $urandom};
        tio2_meta_i = {$urandom, $urandom}; tio3_meta_i = {$urandom, $urandom};
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0; ce_i = 1'b0; run_en_i = 1'b0; holdoff_len_i = 16'd0; trig_i = 1'b0;
        event_done_i = 1'b0; ev_ready_i = 1'b0;
        tio0_meta_i = '0; tio1_meta_i = '0; tio2_meta_i = '0; tio3_meta_i = '0;
        repeat (2) @(negedge clk_i);
        model_reset();
        popped.delete();
        rst_n_i = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (ev_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", ev_valid_o); end
        n_vec++; if (holdoff_o !== 1'b0) begin n_err++; $display("FAIL reset_holdoff got %b exp 0", holdoff_o); end
        n_vec++; if (dead_o !== 1'b1) begin n_err++; $display("FAIL reset_dead got %b exp 1", dead_o); end
        n_vec++; if (drop_count_o !== 16'd0) begin n_err++; $display("FAIL reset_drops got %0d exp 0", drop_count_o); end
        n_vec++; if ({ev_number_o, ev_time_o, ev_meta_o} !== 320'd0) begin n_err++; $display("FAIL reset_data got %h exp 0", {ev_number_o, ev_time_o, ev_meta_o}); end
    endtask

    task automatic test_single();
        logic [255:0] meta;
        int hcnt, guard;
        do_reset();
        run_en_i = 1'b1; ev_ready_i = 1'b0; holdoff_len_i = 16'd3;
        tick();
        n_vec++; if (dead_o !== 1'b0) begin n_err++; $display("FAIL single_dead_run got %b exp 0", dead_o); end
        rand_meta();
        meta = {tio3_meta_i, tio2_meta_i, tio1_meta_i, tio0_meta_i};
        trig_i = 1'b1; tick(); trig_i = 1'b0;
        n_vec++; if (ev_valid_o !== 1'b1) begin n_err++; $display("FAIL single_valid got %b exp 1", ev_valid_o); end
        n_vec++; if (ev_number_o !== 32'd0) begin n_err++; $display("FAIL single_number got %0d exp 0", ev_number_o); end
        n_vec++; if (ev_time_o !== 32'd1) begin n_err++; $display("FAIL single_time got %0d exp 1", ev_time_o); end
        n_vec++; if (ev_meta_o !== meta) begin n_err++; $display("FAIL single_meta got %h exp %h", ev_meta_o, meta); end
        hcnt = 0; guard = 0;
        while (holdoff_o && guard < 20) begin
            if (ce_i) hcnt++;
            tick(); guard++;
        end
        n_vec++; if (hcnt != 3) begin n_err++; $display("FAIL single_holdoff_ce got %0d exp 3", hcnt); end
    endtask

    task automatic test_outstand();
        int guard;
        do_reset();
        run_en_i = 1'b1; ev_ready_i = 1'b1; holdoff_len_i = 16'd1;
        tick();
        for (int k = 0; k < 9; k++) begin
            trig_i = 1'b1; tick(); trig_i = 1'b0;
            n_vec++; if (dead_o !== (k >= 7)) begin n_err++; $display("FAIL outstand_dead_%0d got %b exp %b", k, dead_o, k >= 7); end
            guard = 0;
            while (holdoff_o && guard < 10) begin tick(); guard++; end
            n_vec++; if (holdoff_o) begin n_err++; $display("FAIL outstand_holdoff_timeout got 1 exp 0"); end
            tick();
        end
        repeat (3) tick();
        n_vec++; if (popped.size() != 8) begin n_err++; $display("FAIL outstand_count got %0d exp 8", popped.size()); end
        for (int i = 0; i < popped.size() && i < 8; i++) begin
            n_vec++; if (popped[i] !== 32'(i)) begin n_err++; $display("FAIL outstand_order_%0d got %0d exp %0d", i, popped[i], i); end
        end
        n_vec++; if (drop_count_o !== (STATS ? 16'd1 : 16'd0)) begin n_err++; $display("FAIL outstand_drops got %0d exp %0d", drop_count_o, STATS ? 1 : 0); end
    endtask

    task automatic test_fifo_full();
        do_reset();
        run_en_i = 1'b1; ev_ready_i = 1'b0; holdoff_len_i = 16'd0;
        tick();
        for (int k = 0; k < 4; k++) begin
            trig_i = 1'b1; tick();
            n_vec++; if (dead_o !== (k == 3)) begin n_err++; $display("FAIL full_dead_%0d got %b exp %b", k, dead_o, k == 3); end
        end
        tick(); trig_i = 1'b0;
        n_vec++; if (ev_number_o !== 32'd0) begin n_err++; $display("FAIL full_head got %0d exp 0", ev_number_o); end
        n_vec++; if (drop_count_o !== (STATS ? 16'd1 : 16'd0)) begin n_err++; $display("FAIL full_drops got %0d exp %0d", drop_count_o, STATS ? 1 : 0); end
        ev_ready_i = 1'b1; popped.delete();
        tick();
        n_vec++; if (dead_o !== 1'b0) begin n_err++; $display("FAIL full_dead_after_pop got %b exp 0", dead_o); end
        repeat (5) tick();
        n_vec++; if (popped.size() != 4) begin n_err++; $display("FAIL full_pop_count got %0d exp 4", popped.size()); end
        for (int i = 0; i < popped.size() && i < 4; i++) begin
            n_vec++; if (popped[i] !== 32'(i)) begin n_err++; $display("FAIL full_order_%0d got %0d exp %0d", i, popped[i], i); end
        end
    endtask

    task automatic test_done_overlap();
        do_reset();
        run_en_i = 1'b1; ev_ready_i = 1'b1; holdoff_len_i = 16'd0;
        tick();
        trig_i = 1'b1; repeat (5) tick();
        event_done_i = 1'b1; tick(); event_done_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++; if (dead_o !== (k == 2)) begin n_err++; $display("FAIL overlap_dead_%0d got %b exp %b", k, dead_o, k == 2); end
        end
        trig_i = 1'b0;
        do_reset();
        run_en_i = 1'b1; ev_ready_i = 1'b1;
        tick();
        event_done_i = 1'b1; tick(); event_done_i = 1'b0; tick();
        event_done_i = 1'b1; tick(); event_done_i = 1'b0;
        trig_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_vec++; if (dead_o !== (k == 7)) begin n_err++; $display("FAIL underflow_dead_%0d got %b exp %b", k, dead_o, k == 7); end
        end
        trig_i = 1'b0;
    endtask

    task automatic test_drain();
        do_reset();
        run_en_i = 1'b1; ev_ready_i = 1'b1; holdoff_len_i = 16'd0;
        tick();
        trig_i = 1'b1; repeat (2) tick(); trig_i = 1'b0;
        tick();
        run_en_i = 1'b0; tick();
        n_vec++; if (dead_o !== 1'b1) begin n_err++; $display("FAIL drain_dead got %b exp 1", dead_o); end
        event_done_i = 1'b1; tick(); event_done_i = 1'b0;
        n_vec++; if (dead_o !== 1'b1) begin n_err++; $display("FAIL drain_dead_one got %b exp 1", dead_o); end
        event_done_i = 1'b1; tick(); event_done_i = 1'b0;
        tick();
        run_en_i = 1'b1; tick();
        n_vec++; if (dead_o !== 1'b0) begin n_err++; $display("FAIL drain_rerun_dead got %b exp 0", dead_o); end
        ev_ready_i = 1'b0;
        trig_i = 1'b1; tick(); trig_i = 1'b0;
        n_vec++; if (ev_valid_o !== 1'b1 || ev_number_o !== 32'd0) begin n_err++; $display("FAIL drain_rerun_number got v=%b n=%0d exp v=1 n=0", ev_valid_o, ev_number_o); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        run_en_i = 1'b1; ev_ready_i = 1'b0; holdoff_len_i = 16'd0;
        tick();
        trig_i = 1'b1; repeat (3) tick(); trig_i = 1'b0;
        n_vec++; if (ev_valid_o !== 1'b1) begin n_err++; $display("FAIL midrst_pre_valid got %b exp 1", ev_valid_o); end
        #2 rst_n_i = 1'b0;
        #1;
        n_vec++; if (ev_valid_o !== 1'b0) begin n_err++; $display("FAIL midrst_valid got %b exp 0", ev_valid_o); end
        n_vec++; if (dead_o !== 1'b1) begin n_err++; $display("FAIL midrst_dead got %b exp 1", dead_o); end
        @(negedge clk_i);
        model_reset(); popped.delete();
        rst_n_i = 1'b1;
        tick();
        trig_i = 1'b1; tick(); trig_i = 1'b0;
        n_vec++; if (ev_time_o !== 32'd1 || ev_number_o !== 32'd0) begin n_err++; $display("FAIL midrst_restart got t=%0d n=%0d exp t=1 n=0", ev_time_o, ev_number_o); end
    endtask

    task automatic test_random();
        logic [15:0] exp_drop;
        do_reset();
        run_en_i = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 49) == 0) run_en_i = ~run_en_i;
            trig_i = ($urandom_range(0, 2) == 0);
            event_done_i = ($urandom_range(0, 3) == 0);
            ev_ready_i = $urandom_range(0, 1) == 1;
            holdoff_len_i = 16'($urandom_range(0, 4));
            rand_meta();
            tick();
            exp_drop = STATS ? 16'(m_drops) : 16'd0;
            n_vec++; if (ev_valid_o !== (mq.size() > 0)) begin n_err++; $display("FAIL rand_valid c=%0d got %b exp %b", c, ev_valid_o, mq.size() > 0); end
            n_vec++; if (holdoff_o !== (m_hold != 0)) begin n_err++; $display("FAIL rand_holdoff c=%0d got %b exp %b", c, holdoff_o, m_hold != 0); end
            n_vec++; if (dead_o !== m_dead) begin n_err++; $display("FAIL rand_dead c=%0d got %b exp %b", c, dead_o, m_dead); end
            n_vec++; if (drop_count_o !== exp_drop) begin n_err++; $display("FAIL rand_drops c=%0d got %0d exp %0d", c, drop_count_o, exp_drop); end
            if (mq.size() > 0) begin
                n_vec++;
                if (ev_number_o !== mq[0].num || ev_time_o !== mq[0].t || ev_meta_o !== mq[0].meta) begin
                    n_err++;
                    $display("FAIL rand_head c=%0d got n=%0d t=%0d m=%h exp n=%0d t=%0d m=%h", c, ev_number_o, ev_time_o, ev_meta_o, mq[0].num, mq[0].t, mq[0].meta);
                end
            end
        end
        trig_i = 1'b0; event_done_i = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        test_reset();
        test_single();
        test_outstand();
        test_fifo_full();
        test_done_overlap();
        test_drain();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
